// File: rtl/enc_code_fifo_pkg.sv
// Shared constants and types for the encoder code FIFO.
// The optional duplicate-suppression feature is enabled by ENC_CODE_FIFO_DEDUP_EN.
package enc_code_fifo_pkg;

  localparam int CODE_W_DEF = 3;
  localparam int DEPTH_DEF  = 4;

  typedef logic [CODE_W_DEF-1:0]         code_t;
  typedef logic [$clog2(DEPTH_DEF)-1:0]  ptr_t;
  typedef logic [$clog2(DEPTH_DEF):0]    cnt_t;

endpackage

// File: rtl/enc_code_fifo_ram.sv
// DEPTH x CODE_W register array: one synchronous write port and one
// asynchronous (show-ahead) read port. Cleared on reset so the head value
// reads 0 after any reset, including one asserted mid-operation.
module enc_code_fifo_ram
  import enc_code_fifo_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CODE_W = CODE_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [CODE_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [CODE_W-1:0]        rdata
);

  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [CODE_W-1:0] mem_d [DEPTH];

  // Next array contents: only the addressed word changes on a write.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Storage flops with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/enc_code_fifo.sv
// Buffers priority-encoder codes in a small first-word-fall-through FIFO.
// Optional feature macro: ENC_CODE_FIFO_DEDUP_EN (suppresses a push whose
// code repeats the request of the immediately preceding cycle).
//
// Handshake: an entry transfers at a rising edge exactly when out_valid and
// out_ready are both high; out_valid never depends on out_ready, and out_code
// is stable while out_valid is high and no transfer occurs.
module enc_code_fifo
  import enc_code_fifo_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CODE_W = CODE_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [CODE_W-1:0]      in_code,
  input  logic                   in_valid,
  output logic [CODE_W-1:0]      out_code,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  input  logic                   ovf_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             ovf_q,    ovf_d;

  logic push_req;
  logic pop;
  logic push_acc;
  logic push_rej;

`ifdef ENC_CODE_FIFO_DEDUP_EN
  logic [CODE_W-1:0] last_code_q, last_code_d;
  logic              last_req_q,  last_req_d;
  logic              raw_req;

  // Suppress a request that repeats the previous cycle's request and code.
  always_comb begin
    raw_req     = en & in_valid;
    push_req    = raw_req & ~(last_req_q & (last_code_q == in_code));
    last_req_d  = raw_req;
    last_code_d = in_code;
  end
`else
  // Every enabled, valid encoder cycle requests a push.
  always_comb begin
    push_req = en & in_valid;
  end
`endif

  // Flags come straight from the registered occupancy.
  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign out_valid = ~empty;
  assign count     = count_q;
  assign overflow  = ovf_q;

  // Push/pop decisions and next pointer, count and overflow state.
  always_comb begin
    pop      = out_valid & out_ready;
    push_acc = push_req & (~full | pop);
    push_rej = push_req & full & ~pop;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_acc, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A rejected push in the same cycle as a clear leaves the flag set.
    if (push_rej) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
`ifdef ENC_CODE_FIFO_DEDUP_EN
      last_code_q <= '0;
      last_req_q  <= 1'b0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
`ifdef ENC_CODE_FIFO_DEDUP_EN
      last_code_q <= last_code_d;
      last_req_q  <= last_req_d;
`endif
    end
  end

  enc_code_fifo_ram #(
    .DEPTH  (DEPTH),
    .CODE_W (CODE_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (push_acc),
    .waddr (wr_ptr_q),
    .wdata (in_code),
    .raddr (rd_ptr_q),
    .rdata (out_code)
  );

endmodule

// File: tb/tb_enc_code_fifo.sv
// Self-checking bench for enc_code_fifo: directed scenarios followed by
// random traffic, checked by a queue-based reference model and a monitor.
module tb_enc_code_fifo;

  localparam int DEPTH  = 4;
  localparam int CODE_W = 3;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic              en;
  logic [CODE_W-1:0] in_code;
  logic              in_valid;
  logic [CODE_W-1:0] out_code;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              ovf_clr;

  int n_chk;
  int n_fail;

  // Reference model state.
  logic [CODE_W-1:0] exp_q[$];
  int                m_cnt;
  logic              m_ovf;
  logic              m_prev_req;
  logic [CODE_W-1:0] m_prev_code;

  enc_code_fifo #(
    .DEPTH  (DEPTH),
    .CODE_W (CODE_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_code   (in_code),
    .in_valid  (in_valid),
    .out_code  (out_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of accepted codes, occupancy and sticky overflow,
  // updated at each rising edge from the inputs the bench drove.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_cnt       = 0;
      m_ovf       = 1'b0;
      m_prev_req  = 1'b0;
      m_prev_code = '0;
    end else begin
      logic raw, req, pop_m, acc, rej;
      raw = en & in_valid;
      req = raw;
`ifdef ENC_CODE_FIFO_DEDUP_EN
      if (m_prev_req && (m_prev_code == in_code)) req = 1'b0;
`endif
      m_prev_req  = raw;
      m_prev_code = in_code;
      pop_m = (m_cnt > 0) && out_ready;
      acc   = req && ((m_cnt < DEPTH) || pop_m);
      rej   = req && !acc;
      if (acc) exp_q.push_back(in_code);
      m_cnt = m_cnt + (acc ? 1 : 0) - (pop_m ? 1 : 0);
      if (rej) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end
  end

  // Monitor: between edges, compare flags and the head entry; retire the
  // head from the expected queue when the consumer takes it.
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", int'(out_valid), (m_cnt > 0) ? 1 : 0);
      chk("count", int'(count), m_cnt);
      chk("full", int'(full), (m_cnt == DEPTH) ? 1 : 0);
      chk("empty", int'(empty), (m_cnt == 0) ? 1 : 0);
      chk("overflow", int'(overflow), int'(m_ovf));
      if (m_cnt > 0) begin
        if (exp_q.size() == 0) begin
          chk("exp_q_nonempty", 0, 1);
        end else begin
          chk("out_code", int'(out_code), int'(exp_q[0]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Driver: apply one cycle of inputs, then move to just after the next edge.
  task automatic cyc(input logic e, input logic v, input logic [CODE_W-1:0] c,
                     input logic r, input logic clr);
    en        = e;
    in_valid  = v;
    in_code   = c;
    out_ready = r;
    ovf_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic fill_0123();
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, CODE_W'(i), 1'b0, 1'b0);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    en = 1'b0; in_valid = 1'b0; in_code = '0; out_ready = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_code", int'(out_code), 0);
    rst = 1'b0;
    idle(1);

    // Fill then drain in order.
    fill_0123();
    idle(1);
    drain(5);

    // Overflow: push 7 into a full FIFO, drain, then clear the flag.
    fill_0123();
    cyc(1'b1, 1'b1, 3'd7, 1'b0, 1'b0);
    idle(1);
    drain(5);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    idle(1);

    // Simultaneous push and pop at full.
    fill_0123();
    cyc(1'b1, 1'b1, 3'd5, 1'b1, 1'b0);
    drain(5);

    // Enable low blocks pushes.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 3'd6, 1'b0, 1'b0);
    idle(1);

    // Streaming across pointer wrap.
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, CODE_W'(i % 8), 1'b1, 1'b0);
    drain(3);

    // Held codes: 4,4 then 6,6.
    cyc(1'b1, 1'b1, 3'd4, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 3'd4, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 3'd6, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 3'd6, 1'b0, 1'b0);
    idle(1);
    drain(5);

    // Asynchronous reset mid-cycle while full with overflow set.
    fill_0123();
    cyc(1'b1, 1'b1, 3'd2, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_code", int'(out_code), 0);
    chk("arst_count", int'(count), 0);
    chk("arst_empty", int'(empty), 1);
    chk("arst_full", int'(full), 0);
    chk("arst_overflow", int'(overflow), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
          CODE_W'($urandom_range(0, 7)), 1'($urandom_range(0, 9) < 6),
          1'($urandom_range(0, 15) == 0));
    end
    drain(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
